axi_zero_pad_var: RTL and testbench
===================================

// Module: axi_zero_pad_var
// PURPOSE
//  Streaming zero-pad/truncate engine for RFNoC compute blocks; runtime-programmable successor to fixed-length padding.
//  Pads short packets with a fill word up to L items, optionally truncates long ones, or passes through.
//  L and mode are written over the block settings bus and apply only at packet boundaries.
//  Sits between the axi_wrapper m_axis_data and s_axis_data ports; the header (tuser) path is handled outside.
// PARAMETERS
//  WIDTH       32          item width, bits
//  LEN_W       16          width of length register and item counter
//  SR_OUT_LEN  129         settings address of L (set_data[LEN_W-1:0])
//  SR_MODE     130         settings address of mode: [0]=pad_en, [1]=trunc_en
//  DEFAULT_LEN 32          L after reset
//  FILL        {WIDTH{0}}  value emitted for pad items
// PORTS
//  clk         in   1      clock, all logic
//  reset       in   1      synchronous, active-high
//  clear       in   1      sync packet-state clear (strobed at block init)
//  set_stb     in   1      settings strobe
//  set_addr    in   8      settings address
//  set_data    in   32     settings data
//  i_tdata     in   WIDTH  input item
//  i_tlast     in   1      input end of packet
//  i_tvalid    in   1      input valid
//  i_tready    out  1      input ready
//  o_tdata     out  WIDTH  output item
//  o_tlast     out  1      output end of packet
//  o_tvalid    out  1      output valid
//  o_tready    in   1      output ready
//  pad_pkts    out  32     packets that were padded (stats)
//  trunc_pkts  out  32     packets that were truncated (stats)
// BEHAVIOUR
//  Reset: state=S_PASS, cnt=0, L=DEFAULT_LEN, mode=2'b01; i_tready=o_tvalid=0 while reset high; stats=0.
//  Latency 0 in S_PASS (combinational pass); beat = valid&&ready.
//  FSM states: S_PASS, S_PAD, S_DROP. cnt = output items already sent in current packet.
//  S_PASS: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready. On beat:
//   - i_tlast && cnt+1<L && pad_en  -> o_tlast=0, cnt++, -> S_PAD
//   - !i_tlast && cnt+1==L && trunc_en -> o_tlast=1, cnt=0, -> S_DROP
//   - i_tlast otherwise              -> o_tlast=1, cnt=0, stay
//   - else                           -> o_tlast=0, cnt++ (saturates at 2^LEN_W-1, never wraps)
//  S_PAD: o_tdata=FILL, o_tvalid=1, i_tready=0, o_tlast=(cnt+1==L); on beat cnt++; last beat -> S_PASS, cnt=0.
//  S_DROP: i_tready=1, o_tvalid=0; input discarded; i_tvalid&&i_tlast -> S_PASS.
//  L=0 or mode=2'b00: pure passthrough (no pad, no truncate), tlast unchanged.
//  Input exactly L items: passes unchanged, no pad, no drop.
//  clear: same cycle-after effect as reset on FSM/cnt/stats; config registers retained.
//  o_tvalid must not drop once asserted in S_PAD until beat (AXI rule); S_PASS inherits input's behaviour.
// CONFIGURATION
//  Shadow L/mode written on set_stb && set_addr match; active copy loads from shadow only
//   when state==S_PASS && cnt==0 and no beat this cycle; mid-packet writes affect next packet.
//  Write and packet start in same cycle: the packet uses previous active values.
//  `ZERO_PAD_STATS_EN defined: pad_pkts increments on entry to S_PAD, trunc_pkts on entry to S_DROP;
//   32-bit, wrap at 2^32, zeroed by reset/clear. Undefined: both ports tied to 32'd0, no counter logic.
// STRUCTURE
//  Package zero_pad_pkg: state encoding, SR_OUT_LEN/SR_MODE defaults, MODE_PAD_BIT=0, MODE_TRUNC_BIT=1.
//  Sub-module zero_pad_cfg: shadow+active L/mode registers (setting_reg-based) with boundary load.
//  Top: FSM, cnt, output mux, optional stats counters.
// TESTING
//  L=8, mode=01, 3-item packet -> 3 data + 5 FILL, tlast on item 8; pad_pkts=1.
//  L=4, mode=11, 10-item packet -> 4 items, tlast on 4th, 6 dropped with i_tready=1; trunc_pkts=1.
//  L=4, mode=01, 10-item packet -> all 10 passed, tlast on 10th; no pad.
//  Write L=6 mid 3-of-8 packet at L=8 -> current packet 8 items, next 2-item packet padded to 6.
//  Random o_tready backpressure (50%) across pad/drop: no lost/duplicated items, o_tdata stable while stalled.
//  clear asserted in S_PAD after 2 of 5 pad items -> next cycle S_PASS, cnt=0, new packet starts clean.

Source files
------------

// File: rtl/zero_pad_pkg.sv
// Shared definitions for the runtime-programmable zero-pad/truncate engine.
//  - state_e        : FSM encoding (pass-through, fill-word padding, drop tail)
//  - SrOutLenDefault: default settings address of the output length L
//  - SrModeDefault  : default settings address of the mode word
//  - ModePadBit / ModeTruncBit: bit positions inside the mode word
//  - ModeDefault    : mode after reset (pad enabled, truncate disabled)
package zero_pad_pkg;

    typedef enum logic [1:0] {
        StPass = 2'd0,
        StPad  = 2'd1,
        StDrop = 2'd2
    } state_e;

    localparam logic [7:0]  SrOutLenDefault = 8'd129;
    localparam logic [7:0]  SrModeDefault   = 8'd130;
    localparam int unsigned ModePadBit      = 0;
    localparam int unsigned ModeTruncBit    = 1;
    localparam logic [1:0]  ModeDefault     = 2'b01;

endpackage

// File: rtl/zero_pad_cfg.sv
// Shadow and active copies of the output length L and the mode word.
// Settings-bus writes land in the shadow registers at any time; the active
// copy only follows the shadow when the datapath requests it (load_i), which
// the top asserts at idle packet boundaries so a packet never sees a change.
// Ports:
//  clk_i      : clock
//  reset_i    : synchronous active-high reset (restores DEFAULT_LEN / ModeDefault)
//  set_stb_i  : settings strobe
//  set_addr_i : settings address
//  set_data_i : settings data
//  load_i     : copy shadow into active this cycle
//  len_o      : active length L
//  mode_o     : active mode word
module zero_pad_cfg
    import zero_pad_pkg::*;
#(
    parameter int unsigned      LEN_W       = 16,
    parameter logic [7:0]       SR_OUT_LEN  = SrOutLenDefault,
    parameter logic [7:0]       SR_MODE     = SrModeDefault,
    parameter logic [LEN_W-1:0] DEFAULT_LEN = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             set_stb_i,
    input  logic [7:0]       set_addr_i,
    input  logic [31:0]      set_data_i,
    input  logic             load_i,
    output logic [LEN_W-1:0] len_o,
    output logic [1:0]       mode_o
);

    logic [LEN_W-1:0] len_sh_q, len_q;
    logic [1:0]       mode_sh_q, mode_q;

    // Only the low bits of the settings word carry meaning here.
    logic unused_set_data;
    assign unused_set_data = ^set_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_sh_q  <= DEFAULT_LEN;
            mode_sh_q <= ModeDefault;
            len_q     <= DEFAULT_LEN;
            mode_q    <= ModeDefault;
        end else begin
            if (set_stb_i && (set_addr_i == SR_OUT_LEN)) begin
                len_sh_q <= set_data_i[LEN_W-1:0];
            end
            if (set_stb_i && (set_addr_i == SR_MODE)) begin
                mode_sh_q <= set_data_i[1:0];
            end
            // Load samples the shadow as it was before any same-cycle write.
            if (load_i) begin
                len_q  <= len_sh_q;
                mode_q <= mode_sh_q;
            end
        end
    end

    assign len_o  = len_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/axi_zero_pad_var.sv
// Streaming zero-pad / truncate engine with runtime-programmable length L.
// Short packets are padded with FILL up to L items, long packets are optionally
// cut at L with the tail discarded, everything else passes through untouched.
// Configuration macro: ZERO_PAD_STATS_EN enables the pad/truncate packet
// counters; without it pad_pkts/trunc_pkts are constant zero.
// Ports:
//  clk, reset, clear            : clock, sync active-high reset, sync packet-state clear
//  set_stb, set_addr, set_data  : settings bus (L and mode)
//  i_tdata/i_tlast/i_tvalid/i_tready : input stream
//  o_tdata/o_tlast/o_tvalid/o_tready : output stream
//  pad_pkts, trunc_pkts         : packet statistics
module axi_zero_pad_var
    import zero_pad_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      LEN_W       = 16,
    parameter logic [7:0]       SR_OUT_LEN  = SrOutLenDefault,
    parameter logic [7:0]       SR_MODE     = SrModeDefault,
    parameter int unsigned      DEFAULT_LEN = 32,
    parameter logic [WIDTH-1:0] FILL        = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [31:0]      pad_pkts,
    output logic [31:0]      trunc_pkts
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_act;
    logic [1:0]       mode_act;
    logic             pass_beat;
    logic             cfg_load;

    // Compare in LEN_W+1 bits so cnt+1 never overflows against L.
    logic [LEN_W:0]   cnt_p1;
    logic [LEN_W:0]   len_x;
    logic [LEN_W-1:0] cnt_sat;
    logic             pad_hit;
    logic             trunc_hit;
    logic             pad_last;

    assign cnt_p1  = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
    assign len_x   = {1'b0, len_act};
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

    // L=0 makes both conditions unreachable, giving plain pass-through.
    assign pad_hit   = i_tlast && (cnt_p1 < len_x) && mode_act[ModePadBit];
    assign trunc_hit = !i_tlast && (cnt_p1 == len_x) && mode_act[ModeTruncBit];
    assign pad_last  = (cnt_p1 == len_x);

    assign pass_beat = (state_q == StPass) && i_tvalid && o_tready;
    assign cfg_load  = (state_q == StPass) && (cnt_q == '0) && !pass_beat;

    zero_pad_cfg #(
        .LEN_W       (LEN_W),
        .SR_OUT_LEN  (SR_OUT_LEN),
        .SR_MODE     (SR_MODE),
        .DEFAULT_LEN (LEN_W'(DEFAULT_LEN))
    ) u_cfg (
        .clk_i      (clk),
        .reset_i    (reset),
        .set_stb_i  (set_stb),
        .set_addr_i (set_addr),
        .set_data_i (set_data),
        .load_i     (cfg_load),
        .len_o      (len_act),
        .mode_o     (mode_act)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_tdata  = i_tdata;
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        i_tready = 1'b0;

        case (state_q)
            StPass: begin
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                o_tlast  = pad_hit ? 1'b0 : (trunc_hit ? 1'b1 : i_tlast);
                if (pass_beat) begin
                    if (pad_hit) begin
                        cnt_d   = cnt_sat;
                        state_d = StPad;
                    end else if (trunc_hit) begin
                        cnt_d   = '0;
                        state_d = StDrop;
                    end else if (i_tlast) begin
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
            end
            StPad: begin
                o_tdata  = FILL;
                o_tvalid = 1'b1;
                o_tlast  = pad_last;
                if (o_tready) begin
                    if (pad_last) begin
                        cnt_d   = '0;
                        state_d = StPass;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
            end
            StDrop: begin
                i_tready = 1'b1;
                if (i_tvalid && i_tlast) begin
                    state_d = StPass;
                end
            end
            default: begin
                state_d = StPass;
                cnt_d   = '0;
            end
        endcase

        // Hold both handshakes low for the whole reset pulse.
        if (reset) begin
            i_tready = 1'b0;
            o_tvalid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= StPass;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ZERO_PAD_STATS_EN
    logic [31:0] pad_pkts_q, trunc_pkts_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pad_pkts_q   <= '0;
            trunc_pkts_q <= '0;
        end else begin
            if ((state_q == StPass) && (state_d == StPad)) begin
                pad_pkts_q <= pad_pkts_q + 32'd1;
            end
            if ((state_q == StPass) && (state_d == StDrop)) begin
                trunc_pkts_q <= trunc_pkts_q + 32'd1;
            end
        end
    end

    assign pad_pkts   = pad_pkts_q;
    assign trunc_pkts = trunc_pkts_q;
`else
    assign pad_pkts   = 32'd0;
    assign trunc_pkts = 32'd0;
`endif

endmodule

// File: tb/tb_axi_zero_pad_var.sv
module tb_axi_zero_pad_var;

`ifdef ZERO_PAD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic        o_tlast, o_tvalid, o_tready;
    logic [31:0] pad_pkts, trunc_pkts;

    int assertions = 0;
    int failures   = 0;
    int exp_pad    = 0;
    int exp_trunc  = 0;

    logic [31:0] out_q[$];
    logic        last_q[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    int          stall_err;
    int          dropped;

    axi_zero_pad_var dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .pad_pkts   (pad_pkts),
        .trunc_pkts (trunc_pkts)
    );

    always #5 clk = ~clk;

    // Expected output packet for an n-item input packet.
    function automatic void model(input int n, input logic [31:0] base, input int len,
                                  input logic [1:0] mode);
        exp_d.delete();
        exp_l.delete();
        if (n < len && mode[0]) begin
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(i < n ? base + i : 32'd0);
                exp_l.push_back(i == len - 1);
            end
        end else if (n > len && len > 0 && mode[1]) begin
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(base + i);
                exp_l.push_back(i == len - 1);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_d.push_back(base + i);
                exp_l.push_back(i == n - 1);
            end
        end
    endfunction

    // First differing index between captured and expected packet, -1 if equal.
    function automatic int pkt_diff();
        int sz;
        sz = (out_q.size() < exp_d.size()) ? out_q.size() : exp_d.size();
        for (int i = 0; i < sz; i++) begin
            if (out_q[i] !== exp_d[i] || last_q[i] !== exp_l[i]) return i;
        end
        if (out_q.size() != exp_d.size()) return sz;
        return -1;
    endfunction

    // Settings write of L then mode, followed by idle cycles for the boundary load.
    task automatic cfg(input logic [15:0] len, input logic [1:0] mode);
        set_stb = 1'b1; set_addr = 8'd129; set_data = {16'd0, len};
        @(posedge clk); #1;
        set_addr = 8'd130; set_data = {30'd0, mode};
        @(posedge clk); #1;
        set_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drive one n-item packet, collect output until tlast seen and all input consumed.
    // Entered and left at posedge+1.
    task automatic xfer(input int n, input logic [31:0] base, input bit bp, input int wr_at,
                        input logic [7:0] wr_addr, input logic [31:0] wr_data);
        int          sent = 0;
        int          cycles = 0;
        bit          got_last = 0;
        bit          wr_done = 0;
        bit          prev_stall = 0;
        bit          timed_out = 0;
        logic [31:0] prev_data = 0;
        out_q.delete();
        last_q.delete();
        stall_err = 0;
        dropped   = 0;
        while (!(sent == n && got_last)) begin
            if (sent < n) begin
                i_tvalid = 1'b1; i_tdata = base + sent; i_tlast = (sent == n - 1);
            end else begin
                i_tvalid = 1'b0; i_tlast = 1'b0;
            end
            o_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!wr_done && sent == wr_at) begin
                set_stb = 1'b1; set_addr = wr_addr; set_data = wr_data; wr_done = 1;
            end else begin
                set_stb = 1'b0;
            end
            @(negedge clk);
            if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_data)) stall_err++;
            if (o_tvalid && o_tready) begin
                out_q.push_back(o_tdata);
                last_q.push_back(o_tlast);
                if (o_tlast) got_last = 1;
            end
            if (i_tvalid && i_tready) begin
                if (!(o_tvalid && o_tready)) dropped++;
                sent++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            @(posedge clk); #1;
            cycles++;
            if (cycles > 500) begin
                timed_out = 1;
                break;
            end
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1; set_stb = 1'b0;
        assertions++;
        if (timed_out) begin
            failures++;
            $display("FAIL xfer_timeout: sent %0d of %0d items, got_last=%0d", sent, n, got_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 0; set_data = 0;
        i_tdata = 0; i_tlast = 0; i_tvalid = 1'b1; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        assertions++;
        if (i_tready !== 1'b0 || o_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: i_tready=%b o_tvalid=%b, want 0 0", i_tready, o_tvalid);
        end
        @(posedge clk); #1;
        reset = 1'b0; i_tvalid = 1'b0;
        @(negedge clk);
        assertions++;
        if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: i_tready=%b o_tvalid=%b, want 1 0", i_tready, o_tvalid);
        end
        assertions++;
        if (pad_pkts !== 32'd0 || trunc_pkts !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: pad=%0d trunc=%0d, want 0 0", pad_pkts, trunc_pkts);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_default_len();
        int d;
        xfer(3, 32'h0000_0A00, 0, -1, 8'd0, 32'd0);
        model(3, 32'h0000_0A00, 32, 2'b01);
        exp_pad += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL default_len: %0d items, differs at %0d, want %0d items", out_q.size(),
                     d, exp_d.size());
        end
    endtask

    task automatic test_pad();
        int d;
        cfg(16'd8, 2'b01);
        xfer(3, 32'h0000_0100, 0, -1, 8'd0, 32'd0);
        model(3, 32'h0000_0100, 8, 2'b01);
        exp_pad += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL pad_pkt: %0d items, differs at %0d, want %0d items", out_q.size(), d,
                     exp_d.size());
        end
        assertions++;
        if (pad_pkts !== exp_pad) begin
            failures++;
            $display("FAIL pad_stats: pad_pkts=%0d want %0d", pad_pkts, exp_pad);
        end
    endtask

    task automatic test_trunc();
        int d;
        cfg(16'd4, 2'b11);
        xfer(10, 32'h0000_0200, 0, -1, 8'd0, 32'd0);
        model(10, 32'h0000_0200, 4, 2'b11);
        exp_trunc += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL trunc_pkt: %0d items, differs at %0d, want %0d items", out_q.size(), d,
                     exp_d.size());
        end
        assertions++;
        if (dropped != 6) begin
            failures++;
            $display("FAIL trunc_drop: dropped %0d want 6", dropped);
        end
        assertions++;
        if (trunc_pkts !== exp_trunc) begin
            failures++;
            $display("FAIL trunc_stats: trunc_pkts=%0d want %0d", trunc_pkts, exp_trunc);
        end
    endtask

    task automatic test_pass_modes();
        int d;
        // Long packet, truncation disabled.
        cfg(16'd4, 2'b01);
        xfer(10, 32'h0000_0300, 0, -1, 8'd0, 32'd0);
        model(10, 32'h0000_0300, 4, 2'b01);
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL pass_long: %0d items, differs at %0d, want %0d", out_q.size(), d,
                     exp_d.size());
        end
        // Exactly L items with both features on.
        cfg(16'd4, 2'b11);
        xfer(4, 32'h0000_0400, 0, -1, 8'd0, 32'd0);
        model(4, 32'h0000_0400, 4, 2'b11);
        d = pkt_diff();
        assertions++;
        if (d != -1 || dropped != 0) begin
            failures++;
            $display("FAIL exact_len: %0d items, differs at %0d, dropped %0d, want 4 0",
                     out_q.size(), d, dropped);
        end
        // L=0 means pure pass-through.
        cfg(16'd0, 2'b11);
        xfer(5, 32'h0000_0480, 0, -1, 8'd0, 32'd0);
        model(5, 32'h0000_0480, 0, 2'b11);
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL zero_len: %0d items, differs at %0d, want 5", out_q.size(), d);
        end
        // mode=00: short packet not padded.
        cfg(16'd6, 2'b00);
        xfer(2, 32'h0000_04C0, 0, -1, 8'd0, 32'd0);
        model(2, 32'h0000_04C0, 6, 2'b00);
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL mode_off: %0d items, differs at %0d, want 2", out_q.size(), d);
        end
        assertions++;
        if (pad_pkts !== exp_pad || trunc_pkts !== exp_trunc) begin
            failures++;
            $display("FAIL pass_stats: pad=%0d trunc=%0d want %0d %0d", pad_pkts, trunc_pkts,
                     exp_pad, exp_trunc);
        end
    endtask

    task automatic test_mid_write();
        int d;
        cfg(16'd8, 2'b11);
        xfer(8, 32'h0000_0600, 0, 3, 8'd129, 32'd6);
        model(8, 32'h0000_0600, 8, 2'b11);
        d = pkt_diff();
        assertions++;
        if (d != -1 || dropped != 0) begin
            failures++;
            $display("FAIL mid_write_cur: %0d items, differs at %0d, dropped %0d, want 8 0",
                     out_q.size(), d, dropped);
        end
        @(posedge clk); #1;
        xfer(2, 32'h0000_0700, 0, -1, 8'd0, 32'd0);
        model(2, 32'h0000_0700, 6, 2'b11);
        exp_pad += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL mid_write_next: %0d items, differs at %0d, want %0d", out_q.size(),
                     d, exp_d.size());
        end
    endtask

    task automatic test_backpressure();
        int d;
        cfg(16'd6, 2'b11);
        xfer(3, 32'h0000_0800, 1, -1, 8'd0, 32'd0);
        model(3, 32'h0000_0800, 6, 2'b11);
        exp_pad += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1 || stall_err != 0) begin
            failures++;
            $display("FAIL bp_pad: %0d items, differs at %0d, stall errors %0d", out_q.size(),
                     d, stall_err);
        end
        xfer(9, 32'h0000_0900, 1, -1, 8'd0, 32'd0);
        model(9, 32'h0000_0900, 6, 2'b11);
        exp_trunc += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1 || stall_err != 0 || dropped != 3) begin
            failures++;
            $display("FAIL bp_trunc: %0d items, differs at %0d, stall %0d, dropped %0d want 3",
                     out_q.size(), d, stall_err, dropped);
        end
        assertions++;
        if (pad_pkts !== exp_pad || trunc_pkts !== exp_trunc) begin
            failures++;
            $display("FAIL bp_stats: pad=%0d trunc=%0d want %0d %0d", pad_pkts, trunc_pkts,
                     exp_pad, exp_trunc);
        end
    endtask

    task automatic test_clear();
        int d;
        cfg(16'd8, 2'b01);
        for (int k = 0; k < 3; k++) begin
            i_tvalid = 1'b1; i_tdata = 32'h0000_0B00 + k; i_tlast = (k == 2); o_tready = 1'b1;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o_tready = 1'b0; clear = 1'b1;
        @(negedge clk);
        assertions++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'd0) begin
            failures++;
            $display("FAIL clear_inpad: o_tvalid=%b o_tdata=%h, want 1 0", o_tvalid, o_tdata);
        end
        @(posedge clk); #1;
        clear = 1'b0; o_tready = 1'b1;
        exp_pad = 0;
        exp_trunc = 0;
        @(negedge clk);
        assertions++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            failures++;
            $display("FAIL clear_state: o_tvalid=%b i_tready=%b, want 0 1", o_tvalid, i_tready);
        end
        assertions++;
        if (pad_pkts !== 32'd0 || trunc_pkts !== 32'd0) begin
            failures++;
            $display("FAIL clear_stats: pad=%0d trunc=%0d, want 0 0", pad_pkts, trunc_pkts);
        end
        @(posedge clk); #1;
        xfer(3, 32'h0000_0C00, 0, -1, 8'd0, 32'd0);
        model(3, 32'h0000_0C00, 8, 2'b01);
        exp_pad += STATS;
        d = pkt_diff();
        assertions++;
        if (d != -1) begin
            failures++;
            $display("FAIL clear_next: %0d items, differs at %0d, want %0d", out_q.size(), d,
                     exp_d.size());
        end
        assertions++;
        if (pad_pkts !== exp_pad) begin
            failures++;
            $display("FAIL clear_next_stats: pad_pkts=%0d want %0d", pad_pkts, exp_pad);
        end
    endtask

    initial begin
        test_reset();
        test_default_len();
        test_pad();
        test_trunc();
        test_pass_modes();
        test_mid_write();
        test_backpressure();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
